// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the debug overlay BCD scheduler: FSM state encoding,
// sign digit codes and the clamp constant helper.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        SWAP
    } state_e;

    localparam logic [3:0] SIGN_NEG = 4'hA;
    localparam logic [3:0] SIGN_POS = 4'h0;

    // Largest magnitude representable in 'digits' decimal digits (10^digits - 1).
    function automatic longint unsigned max_mag(input int unsigned digits);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial
// Serial double-dabble converter, one iteration per clock.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   start  in   load 'mag' and begin a conversion
//   mag    in   unsigned magnitude, already clamped so it fits NUM_BCD digits
//   bcd    out  NUM_BCD packed BCD nibbles, digit 0 in the low nibble
//   valid  out  one-cycle pulse BIN_W cycles after start; bcd holds until next start
module bin_to_bcd_serial #(
    parameter int unsigned BIN_W   = 16,
    parameter int unsigned NUM_BCD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BIN_W-1:0]       mag,
    output logic [NUM_BCD*4-1:0]   bcd,
    output logic                   valid
);

    localparam int unsigned BCD_W = NUM_BCD * 4;
    localparam int unsigned REG_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // {bcd digits, remaining binary bits}
    logic [REG_W-1:0] shreg_q, shreg_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_comb begin
        adj = shreg_q;
        for (int unsigned i = 0; i < NUM_BCD; i++) begin
            if (adj[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
            end
        end

        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (start) begin
            // The first iteration is folded into the load: with all digits zero the
            // add-3 step is a no-op, so only the shift remains.
            shreg_d = {{BCD_W{1'b0}}, mag} << 1;
            cnt_d   = CNT_W'(BIN_W - 1);
        end else if (cnt_q != '0) begin
            shreg_d = adj << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            valid_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign bcd   = shreg_q[REG_W-1 -: BCD_W];
    assign valid = valid_q;

endmodule

// File: rtl/debug_bcd_scheduler.sv
// debug_bcd_scheduler
// Snapshots NUM_VARS signed debug values per frame and converts them one at a
// time through a shared serial BCD engine into a double-buffered digit store.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset; aborts conversion, clears buffers
//   frame_start  in   snapshot request, accepted only while not busy
//   vars_in      in   packed variables, var k at [k*SEQ_LEN +: SEQ_LEN]
//   rd_var       in   read variable index
//   rd_digit     in   read digit index, 0 = LSD, SEQ_DIGIT-1 = sign digit
//   rd_code      out  registered digit code from the front buffer (0 if out of range)
//   busy         out  conversion in progress
//   done         out  one-cycle pulse in the buffer swap cycle
//   overrun      out  one-cycle pulse after frame_start arrived while busy
module debug_bcd_scheduler
    import debug_pkg::*;
#(
    parameter int unsigned NUM_VARS  = 4,
    parameter int unsigned SEQ_LEN   = 16,
    parameter int unsigned SEQ_DIGIT = SEQ_LEN / 4 + 1,
    localparam int unsigned VAR_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
    localparam int unsigned DIG_W    = $clog2(SEQ_DIGIT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic [NUM_VARS*SEQ_LEN-1:0] vars_in,
    input  logic [VAR_W-1:0]            rd_var,
    input  logic [DIG_W-1:0]            rd_digit,
    output logic [3:0]                  rd_code,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int unsigned NUM_BCD = SEQ_DIGIT - 1;
    localparam logic [SEQ_LEN-1:0] MAX_MAG = SEQ_LEN'(max_mag(NUM_BCD));

    state_e                      state_q, state_d;
    logic [NUM_VARS*SEQ_LEN-1:0] snap_q;
    logic [VAR_W-1:0]            k_q;
    logic                        buf_sel_q;   // selects the front buffer
    logic [3:0]                  buf_q [2][NUM_VARS][SEQ_DIGIT];
    logic [3:0]                  rd_code_q;
    logic                        overrun_q;

    logic                        accept;
    logic [SEQ_LEN-1:0]          cur_val, cur_neg, cur_mag, cur_mag_clamped;
    logic                        cur_sign;
    logic [NUM_BCD*4-1:0]        bcd;
    logic                        bcd_valid;
    logic [3:0]                  rd_data;

    // Current variable: sign/magnitude split with clamp. The snapshot and k stay
    // stable through STORE, so the sign is recomputed there rather than held.
    always_comb begin
        cur_val  = snap_q[k_q*SEQ_LEN +: SEQ_LEN];
        cur_sign = cur_val[SEQ_LEN-1];
        cur_neg  = -cur_val;
        cur_mag  = cur_sign ? cur_neg : cur_val;
        cur_mag_clamped = (cur_mag > MAX_MAG) ? MAX_MAG : cur_mag;
    end

    bin_to_bcd_serial #(
        .BIN_W   (SEQ_LEN),
        .NUM_BCD (NUM_BCD)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (state_q == LOAD),
        .mag   (cur_mag_clamped),
        .bcd   (bcd),
        .valid (bcd_valid)
    );

    always_comb begin
        state_d = state_q;
        busy    = (state_q == LOAD) || (state_q == SHIFT) || (state_q == STORE);
        done    = (state_q == SWAP);
        accept  = frame_start && !busy;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (bcd_valid) state_d = STORE;
            STORE:   state_d = (k_q == VAR_W'(NUM_VARS - 1)) ? SWAP : LOAD;
            SWAP:    state_d = accept ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data = 4'h0;
        if ((32'(rd_var) < NUM_VARS) && (32'(rd_digit) < SEQ_DIGIT)) begin
            rd_data = buf_q[buf_sel_q][rd_var][rd_digit];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            k_q       <= '0;
            buf_sel_q <= 1'b0;
            rd_code_q <= 4'h0;
            overrun_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int v = 0; v < NUM_VARS; v++) begin
                    for (int d = 0; d < SEQ_DIGIT; d++) begin
                        buf_q[b][v][d] <= 4'h0;
                    end
                end
            end
        end else begin
            state_q   <= state_d;
            overrun_q <= frame_start && busy;
            // Read uses the pre-swap select, so a SWAP-cycle read returns old data.
            rd_code_q <= rd_data;
            if (accept) begin
                snap_q <= vars_in;
                k_q    <= '0;
            end
            if (state_q == STORE) begin
                for (int d = 0; d < NUM_BCD; d++) begin
                    buf_q[~buf_sel_q][k_q][d] <= bcd[4*d +: 4];
                end
                buf_q[~buf_sel_q][k_q][SEQ_DIGIT-1] <= cur_sign ? SIGN_NEG : SIGN_POS;
                k_q <= k_q + VAR_W'(1);
            end
            if (state_q == SWAP) begin
                buf_sel_q <= ~buf_sel_q;
            end
        end
    end

    assign rd_code = rd_code_q;
    assign overrun = overrun_q;

endmodule
